add_pipe_n: RTL and testbench

//  Parametrised, pipelined N-bit adder/subtractor with valid/ready handshake on both sides.

---
 rtl/add_pkg.sv | 17 +
 rtl/add_pipe_n_fa_cell.sv | 13 +
 rtl/add_pipe_n.sv | 115 +++++++++++
 tb/tb_add_pipe_n.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined adder/subtractor.
// Slice width is derived from the top-level parameters through slice_w().
package add_pkg;

   localparam int DEF_WIDTH  = 16;
   localparam int DEF_STAGES = 4;

   function automatic bit params_ok(input int width, input int stages);
      return (width >= 1) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
   endfunction

   // Falls back to 1 so an illegal combination still elaborates far enough to hit the $error.
   function automatic int slice_w(input int width, input int stages);
      return params_ok(width, stages) ? (width / stages) : 1;
   endfunction

endpackage

// File: rtl/add_pipe_n_fa_cell.sv
// One-bit full adder; the ripple element of every pipeline slice.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/add_pipe_n.sv
// Skewed-pipeline N-bit adder/subtractor: one ripple slice per stage, carry registered
// between stages, the whole pipe advancing in lock-step under a single valid/ready stall.
module add_pipe_n
   import add_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int S    = slice_w(WIDTH, STAGES);
   localparam int LAST = STAGES - 1;

   typedef struct packed {
      logic             valid;
      logic             sub;
      logic             carry;
      logic [WIDTH-1:0] a_rem;
      logic [WIDTH-1:0] b_rem;
      logic [WIDTH-1:0] sum_done;
   } stage_t;

   if (!params_ok(WIDTH, STAGES)) begin : gen_param_err
      $error("add_pipe_n: illegal WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
   end

   stage_t stage_q [STAGES];
   stage_t stage_d [STAGES];
   stage_t in_rec;
   logic   ovf_q;
   logic   ovf_d;
   logic   adv;

   assign adv      = !stage_q[LAST].valid || out_ready;
   assign in_ready = adv;

   // Subtraction forces carry-in to 1; the B inversion happens per slice using the travelling sub flag.
   assign in_rec = '{valid: in_valid, sub: sub, carry: sub | cin,
                     a_rem: a, b_rem: b, sum_done: '0};

   for (genvar gi = 0; gi < STAGES; gi++) begin : gen_stage
      stage_t         src;
      stage_t         stage_nxt;
      logic [S-1:0]   op_a;
      logic [S-1:0]   op_b;
      logic [S-1:0]   s_slice;
      logic [S:0]     c;

      if (gi == 0) begin : gen_first
         assign src = in_rec;
      end else begin : gen_rest
         assign src = stage_q[gi-1];
      end

      assign op_a = src.a_rem[gi*S +: S];
      assign op_b = src.b_rem[gi*S +: S] ^ {S{src.sub}};
      assign c[0] = src.carry;

      for (genvar gj = 0; gj < S; gj++) begin : gen_bit
         fa_cell u_fa (
            .a    (op_a[gj]),
            .b    (op_b[gj]),
            .cin  (c[gj]),
            .s    (s_slice[gj]),
            .cout (c[gj+1])
         );
      end

      always_comb begin
         stage_nxt                      = src;
         stage_nxt.carry                = c[S];
         stage_nxt.sum_done[gi*S +: S]  = s_slice;
      end

      assign stage_d[gi] = stage_nxt;

      // Signed overflow: carry into the MSB differs from carry out of it.
      if (gi == LAST) begin : gen_ovf_tap
         assign ovf_d = c[S-1] ^ c[S];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            stage_q[k] <= '0;
         end
         ovf_q <= 1'b0;
      end else if (adv) begin
         for (int k = 0; k < STAGES; k++) begin
            stage_q[k] <= stage_d[k];
         end
         ovf_q <= ovf_d;
      end
   end

   assign out_valid = stage_q[LAST].valid;
   assign sum       = stage_q[LAST].sum_done;
   assign cout      = stage_q[LAST].carry;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_pipe_n.sv
// Directed-vector bench for add_pipe_n (WIDTH=16, STAGES=4) with an in-order scoreboard
// plus hand-written reset, backpressure and bubble sequences.
module tb_add_pipe_n;

   localparam int W = 16;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         sub = 1'b0;
   logic         cin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   always #5 clk = ~clk;

   add_pipe_n #(.WIDTH(W), .STAGES(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
      int          stamp;
      bit          lat;
   } exp_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sub;
      logic        cin;
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   exp_t        sb[$];
   vec_t        tbl [14];
   int          checks = 0;
   int          failures = 0;
   int          step = 0;
   int          produced = 0;
   logic [15:0] e_sum = '0;
   logic        e_cout = 1'b0;
   logic        e_ovf = 1'b0;
   bit          e_lat = 1'b0;
   bit          accepted = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (step %0d)", name, act, req, step);
      end
   endtask

   // One clock: called at a negedge with inputs already driven; samples 1 time unit later.
   task automatic cycle();
      exp_t e;
      #1;
      if (out_valid && out_ready) begin
         produced++;
         if (sb.size() == 0) begin
            chk("unexpected_out", {31'd0, out_valid}, 32'd0);
         end else begin
            e = sb.pop_front();
            $display("out step=%0d sum=%h cout=%b ovf=%b", step, sum, cout, ovf);
            chk("sum", {16'd0, sum}, {16'd0, e.sum});
            chk("cout", {31'd0, cout}, {31'd0, e.cout});
            chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
            if (e.lat) chk("latency", step - e.stamp, N);
         end
      end
      accepted = in_valid && in_ready;
      if (accepted) sb.push_back('{sum: e_sum, cout: e_cout, ovf: e_ovf, stamp: step, lat: e_lat});
      step++;
      @(negedge clk);
   endtask

   task automatic set_op(input logic [15:0] x, input logic [15:0] y, input logic s, input logic c,
                         input logic [15:0] es, input logic ec, input logic ev, input bit lat);
      in_valid = 1'b1;
      a = x;
      b = y;
      sub = s;
      cin = c;
      e_sum = es;
      e_cout = ec;
      e_ovf = ev;
      e_lat = lat;
   endtask

   task automatic offer(input logic [15:0] x, input logic [15:0] y, input logic s, input logic c,
                        input logic [15:0] es, input logic ec, input logic ev, input bit lat);
      set_op(x, y, s, c, es, ec, ev, lat);
      for (int t = 0; t < 50; t++) begin
         cycle();
         if (accepted) break;
      end
      chk("accept_timeout", {31'd0, accepted}, 32'd1);
   endtask

   task automatic drain();
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int t = 0; t < 60; t++) begin
         if (sb.size() == 0) break;
         cycle();
      end
      repeat (N + 2) cycle();
      chk("drain_empty", sb.size(), 0);
   endtask

   function automatic void model(input logic [15:0] x, input logic [15:0] y, input logic s,
                                 input logic c, output logic [15:0] r, output logic co,
                                 output logic v);
      logic [15:0] yy;
      logic [16:0] t;
      yy = s ? ~y : y;
      t  = {1'b0, x} + {1'b0, yy} + {16'd0, (s ? 1'b1 : c)};
      r  = t[15:0];
      co = t[16];
      v  = (x[15] == yy[15]) && (r[15] != x[15]);
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          p0;
      logic [15:0] rs;
      logic        rc;
      logic        rv;

      //            a         b         sub   cin   sum       cout  ovf
      tbl[0]  = '{16'h000B, 16'h0008, 1'b0, 1'b0, 16'h0013, 1'b0, 1'b0};
      tbl[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[2]  = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
      tbl[3]  = '{16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
      tbl[4]  = '{16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
      tbl[5]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
      tbl[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      tbl[7]  = '{16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[8]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      tbl[9]  = '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0};
      tbl[10] = '{16'h7FFF, 16'hFFFF, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
      tbl[11] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0};
      tbl[12] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
      tbl[13] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_sum", {16'd0, sum}, 32'd0);
      chk("rst_cout", {31'd0, cout}, 32'd0);
      chk("rst_ovf", {31'd0, ovf}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
      @(negedge clk);

      // Back-to-back table stream with unstalled latency check
      out_ready = 1'b1;
      foreach (tbl[i]) begin
         offer(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin, tbl[i].sum, tbl[i].cout, tbl[i].ovf, 1'b1);
      end
      drain();

      // Carry-in with bubbles: one result per accepted op
      p0 = produced;
      for (int i = 0; i < 4; i++) begin
         offer(16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1);
         in_valid = 1'b0;
         cycle();
      end
      drain();
      chk("bubble_count", produced - p0, 4);

      // Backpressure: four ops fill the pipe, a fifth waits while the output is held
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         offer(16'h1111 * i, 16'h0101, 1'b0, 1'b0, 16'h1111 * i + 16'h0101, 1'b0, 1'b0, 1'b0);
      end
      set_op(16'h4444, 16'h0101, 1'b0, 1'b0, 16'h4545, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_sum_hold", {16'd0, sum}, 32'h0101);
         @(negedge clk);
      end
      out_ready = 1'b1;
      p0 = produced;
      cycle();
      chk("bp_fifth_accept", {31'd0, accepted}, 32'd1);
      in_valid = 1'b0;
      repeat (4) cycle();
      chk("bp_one_per_cycle", produced - p0, 5);
      drain();

      // Reset mid-stream
      out_ready = 1'b0;
      offer(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);
      offer(16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b0);
      offer(16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      cycle();
      #1;
      chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      chk("pre_rst_sum", {16'd0, sum}, 32'h0003);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_sum", {16'd0, sum}, 32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      out_ready = 1'b1;
      p0 = produced;
      repeat (10) cycle();
      chk("no_stale", produced - p0, 0);

      // Random traffic against the reference model with random backpressure
      for (int i = 0; i < 400; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         sub = 1'($urandom);
         cin = 1'($urandom);
         model(a, b, sub, cin, rs, rc, rv);
         e_sum = rs;
         e_cout = rc;
         e_ovf = rv;
         e_lat = 1'b0;
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
